lane_dispatcher: RTL and testbench

- Sequences one vector-vector operation element by element across NUM_OF_LANES functional lanes.
- Per element it issues paired read requests to the vector register file and collects both operands. It then dispatches them to a free lane chosen round-robin.
- It sits between the execution unit, which sends one command per vector instruction, and the vector register read ports and functional lanes.

---
 rtl/lane_dispatcher_pkg.sv | 20 ++
 rtl/lane_dispatcher_rr.sv | 26 ++
 rtl/lane_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_lane_dispatcher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_dispatcher_pkg.sv
// Shared widths, opcode type and dispatcher state encoding.
package lane_dispatcher_pkg;

    localparam int NUM_OF_LANES = 4;
    localparam int DATA_W       = 64;
    localparam int REG_PTR_W    = 5;
    localparam int LEN_W        = 32;
    localparam int FOP_W        = 4;
    localparam int LANE_IDX_W   = $clog2(NUM_OF_LANES);

    typedef logic [FOP_W-1:0] function_opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } disp_state_t;

endpackage

// File: rtl/lane_dispatcher_rr.sv
// Round-robin free-lane search: first idle lane at or after rr_ptr, wrapping.
module lane_rr_picker
    import lane_dispatcher_pkg::*;
(
    input  logic [NUM_OF_LANES-1:0] lane_busy,
    input  logic [LANE_IDX_W-1:0]   rr_ptr,
    output logic                    found,
    output logic [LANE_IDX_W-1:0]   idx
);

    // walk the lanes from rr_ptr; index arithmetic wraps because the lane count is a power of two
    always_comb begin
        logic [LANE_IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_OF_LANES; k++) begin
            cand = rr_ptr + LANE_IDX_W'(k);
            if (!found && !lane_busy[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lane_dispatcher.sv
// Element-by-element sequencer for one vector-vector command: paired operand
// reads, then round-robin dispatch to a free functional lane.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_rdy high
//   REQ   | read requests out on both ports until each has been granted
//   WAIT  | collecting both operand responses
//   ISSUE | operands held, waiting for a free lane to dispatch to
module lane_dispatcher
    import lane_dispatcher_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [FOP_W-1:0]        cmd_op,
    input  logic [REG_PTR_W-1:0]    cmd_src0,
    input  logic [REG_PTR_W-1:0]    cmd_src1,
    input  logic [REG_PTR_W-1:0]    cmd_dst,
    input  logic [LEN_W-1:0]        cmd_len,
    output logic                    done,
    output logic [1:0]              rd_req_vld,
    output logic [REG_PTR_W-1:0]    rd_req_ptr0,
    output logic [REG_PTR_W-1:0]    rd_req_ptr1,
    output logic [LEN_W-1:0]        rd_req_addr,
    input  logic [1:0]              rd_req_grant,
    input  logic [1:0]              rd_rsp_vld,
    input  logic [DATA_W-1:0]       rd_rsp_data0,
    input  logic [DATA_W-1:0]       rd_rsp_data1,
    input  logic [NUM_OF_LANES-1:0] lane_busy,
    output logic [NUM_OF_LANES-1:0] lane_vld,
    output logic [DATA_W-1:0]       lane_data0,
    output logic [DATA_W-1:0]       lane_data1,
    output logic [REG_PTR_W-1:0]    lane_dst,
    output logic [LEN_W-1:0]        lane_addr,
    output logic [FOP_W-1:0]        lane_op
);

    localparam logic [NUM_OF_LANES-1:0] LANE_ONE = NUM_OF_LANES'(1);

    disp_state_t            state_q, state_d;
    function_opcode_t       op_q;
    logic [REG_PTR_W-1:0]   src0_q, src1_q, dst_q;
    logic [LEN_W-1:0]       len_q, elem_q;
    logic [1:0]             gnt_q, rcvd_q;
    logic [DATA_W-1:0]      opnd0_q, opnd1_q;
    logic [LANE_IDX_W-1:0]  rr_ptr_q, pick_idx;
    logic                   pick_found;
    logic [1:0]             gnt_now, gnt_all, rsp_take, rcvd_all;
    logic                   last_elem;

    lane_rr_picker u_picker (
        .lane_busy (lane_busy),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // request/response bookkeeping; a response counts only once its port has been granted
    always_comb begin
        cmd_rdy     = (state_q == IDLE);
        rd_req_vld  = (state_q == REQ && !flush) ? ~gnt_q : 2'b00;
        rd_req_ptr0 = src0_q;
        rd_req_ptr1 = src1_q;
        rd_req_addr = elem_q;
        gnt_now     = rd_req_vld & rd_req_grant;
        gnt_all     = gnt_q | gnt_now;
        rsp_take    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rsp_take[i] = rd_rsp_vld[i] &&
                          ((state_q == WAIT) || (state_q == REQ && gnt_q[i]));
        end
        rcvd_all    = rcvd_q | rsp_take;
        last_elem   = (elem_q == len_q - LEN_W'(1));
        lane_data0  = opnd0_q;
        lane_data1  = opnd1_q;
        lane_dst    = dst_q;
        lane_op     = op_q;
    end

    // next-state selection; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cmd_vld && cmd_len != '0) state_d = REQ;
                REQ:     if (gnt_all == 2'b11) state_d = WAIT;
                WAIT:    if (rcvd_all == 2'b11) state_d = ISSUE;
                ISSUE:   if (pick_found) state_d = last_elem ? IDLE : REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    // state, command latches, operand capture and registered lane/done strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            elem_q    <= '0;
            gnt_q     <= '0;
            rcvd_q    <= '0;
            opnd0_q   <= '0;
            opnd1_q   <= '0;
            rr_ptr_q  <= '0;
            lane_vld  <= '0;
            lane_addr <= '0;
            done      <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_vld <= '0;
            done     <= 1'b0;
            if (flush) begin
                gnt_q  <= '0;
                rcvd_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_vld) begin
                            if (cmd_len != '0) begin
                                op_q   <= cmd_op;
                                src0_q <= cmd_src0;
                                src1_q <= cmd_src1;
                                dst_q  <= cmd_dst;
                                len_q  <= cmd_len;
                                elem_q <= '0;
                                gnt_q  <= '0;
                                rcvd_q <= '0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        gnt_q <= (gnt_all == 2'b11) ? 2'b00 : gnt_all;
                    end
                    ISSUE: begin
                        if (pick_found) begin
                            lane_vld  <= LANE_ONE << pick_idx;
                            lane_addr <= elem_q;
                            rr_ptr_q  <= pick_idx + LANE_IDX_W'(1);
                            if (last_elem) begin
                                done <= 1'b1;
                            end else begin
                                elem_q <= elem_q + LEN_W'(1);
                                rcvd_q <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
                if (rsp_take[0]) begin
                    opnd0_q   <= rd_rsp_data0;
                    rcvd_q[0] <= 1'b1;
                end
                if (rsp_take[1]) begin
                    opnd1_q   <= rd_rsp_data1;
                    rcvd_q[1] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_dispatcher.sv
// Directed bench for lane_dispatcher: basic run, staggered grants, busy lanes,
// zero length, flush and asynchronous reset.
module tb_lane_dispatcher;
    import lane_dispatcher_pkg::*;

    localparam logic [63:0] D0 = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] D1 = 64'h5A5A_0000_0001_0000;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    flush = 1'b0;
    logic                    cmd_vld = 1'b0;
    logic                    cmd_rdy;
    logic [FOP_W-1:0]        cmd_op = '0;
    logic [REG_PTR_W-1:0]    cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
    logic [LEN_W-1:0]        cmd_len = '0;
    logic                    done;
    logic [1:0]              rd_req_vld;
    logic [REG_PTR_W-1:0]    rd_req_ptr0, rd_req_ptr1;
    logic [LEN_W-1:0]        rd_req_addr;
    logic [1:0]              rd_req_grant = '0;
    logic [1:0]              rd_rsp_vld = '0;
    logic [DATA_W-1:0]       rd_rsp_data0 = '0, rd_rsp_data1 = '0;
    logic [NUM_OF_LANES-1:0] lane_busy = '0;
    logic [NUM_OF_LANES-1:0] lane_vld;
    logic [DATA_W-1:0]       lane_data0, lane_data1;
    logic [REG_PTR_W-1:0]    lane_dst;
    logic [LEN_W-1:0]        lane_addr;
    logic [FOP_W-1:0]        lane_op;

    logic       auto_en = 1'b1;
    logic [1:0] man_grant = '0, man_rsp = '0, gnt_prev = '0;
    int         n_cmp = 0;
    int         n_err = 0;

    lane_dispatcher dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .done(done),
        .rd_req_vld(rd_req_vld), .rd_req_ptr0(rd_req_ptr0), .rd_req_ptr1(rd_req_ptr1),
        .rd_req_addr(rd_req_addr), .rd_req_grant(rd_req_grant),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
        .lane_busy(lane_busy), .lane_vld(lane_vld),
        .lane_data0(lane_data0), .lane_data1(lane_data1),
        .lane_dst(lane_dst), .lane_addr(lane_addr), .lane_op(lane_op)
    );

    always #5 clk = ~clk;

    // register-file model: instant grant, response one cycle later (auto) or scripted (manual)
    always @(negedge clk) begin
        #2;
        rd_rsp_data0 = D0 + {32'd0, rd_req_addr};
        rd_rsp_data1 = D1 + {32'd0, rd_req_addr};
        if (auto_en) begin
            rd_rsp_vld   = gnt_prev;
            rd_req_grant = rd_req_vld;
            gnt_prev     = rd_req_vld;
        end else begin
            rd_rsp_vld   = man_rsp;
            rd_req_grant = man_grant;
            gnt_prev     = 2'b00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [FOP_W-1:0] op,
                            input logic [REG_PTR_W-1:0] dst);
        cmd_vld  = 1'b1;
        cmd_len  = len;
        cmd_op   = op;
        cmd_src0 = 5'd3;
        cmd_src1 = 5'd7;
        cmd_dst  = dst;
        step();
        cmd_vld  = 1'b0;
    endtask

    task automatic check_dispatch(input string tag, input logic [3:0] exp_vld,
                                  input int e, input logic exp_done);
        check_val({tag, " lane_vld"}, 64'(lane_vld), 64'(exp_vld));
        check_val({tag, " lane_addr"}, 64'(lane_addr), 64'(e));
        check_val({tag, " done"}, 64'(done), 64'(exp_done));
        check_val({tag, " data0"}, lane_data0, D0 + 64'(e));
        check_val({tag, " data1"}, lane_data1, D1 + 64'(e));
    endtask

    initial begin
        // reset state
        step(2);
        check_val("rst cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_val("rst lane_vld", 64'(lane_vld), 64'd0);
        check_val("rst rd_req_vld", 64'(rd_req_vld), 64'd0);
        check_val("rst done", 64'(done), 64'd0);
        reset = 1'b1;
        step();

        // basic: four elements, one every 3 cycles, lanes 0..3 in order
        send_cmd(32'd4, 4'h9, 5'd12);
        check_val("basic rd_req_vld", 64'(rd_req_vld), 64'h3);
        check_val("basic ptr0", 64'(rd_req_ptr0), 64'd3);
        check_val("basic ptr1", 64'(rd_req_ptr1), 64'd7);
        check_val("basic cmd_rdy", 64'(cmd_rdy), 64'd0);
        for (int e = 0; e < 4; e++) begin
            step(2);
            check_val("basic gap", 64'(lane_vld), 64'd0);
            step();
            check_dispatch("basic", 4'b0001 << e, e, e == 3);
        end
        check_val("basic dst", 64'(lane_dst), 64'd12);
        check_val("basic op", 64'(lane_op), 64'h9);
        check_val("basic idle", 64'(cmd_rdy), 64'd1);

        // staggered grants: port0 granted first, port1 two cycles later
        auto_en = 1'b0;
        send_cmd(32'd1, 4'h2, 5'd1);
        man_grant = 2'b01;
        step();
        check_val("stag vld after g0", 64'(rd_req_vld), 64'h2);
        man_grant = 2'b00;
        step();
        check_val("stag vld hold", 64'(rd_req_vld), 64'h2);
        man_grant = 2'b10;
        man_rsp   = 2'b01;
        step();
        check_val("stag vld after g1", 64'(rd_req_vld), 64'h0);
        man_grant = 2'b00;
        man_rsp   = 2'b10;
        step();
        check_val("stag no early issue", 64'(lane_vld), 64'd0);
        man_rsp = 2'b00;
        step();
        check_dispatch("stag", 4'b0001, 0, 1'b1);

        // busy lanes: all busy for 5 cycles, then only lane 2 free (rr_ptr=1)
        auto_en   = 1'b1;
        lane_busy = 4'b1111;
        send_cmd(32'd2, 4'h5, 5'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("busy no dispatch", 64'(lane_vld), 64'd0);
        end
        lane_busy = 4'b1011;
        #1;
        check_val("busy registered", 64'(lane_vld), 64'd0);
        step();
        check_dispatch("busy pick2", 4'b0100, 0, 1'b0);
        lane_busy = 4'b0000;
        step(3);
        check_dispatch("busy rr3", 4'b1000, 1, 1'b1);

        // zero length
        send_cmd(32'd0, 4'h1, 5'd0);
        check_val("zero done", 64'(done), 64'd1);
        check_val("zero cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_val("zero rd_req_vld", 64'(rd_req_vld), 64'd0);
        step();
        check_val("zero done pulse", 64'(done), 64'd0);
        check_val("zero still idle", 64'(rd_req_vld), 64'd0);

        // flush with cmd_vld in IDLE drops the command
        flush = 1'b1;
        send_cmd(32'd2, 4'h3, 5'd3);
        flush = 1'b0;
        check_val("flushcmd cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_val("flushcmd rd_req_vld", 64'(rd_req_vld), 64'd0);
        step();
        check_val("flushcmd dropped", 64'(rd_req_vld), 64'd0);

        // flush in WAIT with one operand received, late response, then a fresh command
        auto_en = 1'b0;
        send_cmd(32'd3, 4'h4, 5'd4);
        man_grant = 2'b11;
        step();
        check_val("flush in wait", 64'(rd_req_vld), 64'd0);
        man_grant = 2'b00;
        man_rsp   = 2'b01;
        step();
        flush   = 1'b1;
        man_rsp = 2'b00;
        step();
        flush = 1'b0;
        check_val("flush cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_val("flush done", 64'(done), 64'd0);
        check_val("flush lane_vld", 64'(lane_vld), 64'd0);
        man_rsp = 2'b10;
        step();
        man_rsp = 2'b00;
        check_val("flush late rsp done", 64'(done), 64'd0);
        check_val("flush late rsp idle", 64'(cmd_rdy), 64'd1);
        auto_en = 1'b1;
        send_cmd(32'd1, 4'h6, 5'd5);
        step(3);
        check_dispatch("post flush", 4'b0001, 0, 1'b1);

        // asynchronous reset while stuck in ISSUE on element 1
        send_cmd(32'd3, 4'h7, 5'd6);
        step(3);
        check_dispatch("prerst", 4'b0010, 0, 1'b0);
        lane_busy = 4'b1111;
        step(3);
        check_val("prerst issue cmd_rdy", 64'(cmd_rdy), 64'd0);
        reset = 1'b0;
        #1;
        check_val("arst cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_val("arst rd_req_vld", 64'(rd_req_vld), 64'd0);
        check_val("arst lane_vld", 64'(lane_vld), 64'd0);
        check_val("arst done", 64'(done), 64'd0);
        step();
        check_val("arst no done", 64'(done), 64'd0);
        reset     = 1'b1;
        lane_busy = 4'b0000;
        step();
        send_cmd(32'd1, 4'h8, 5'd7);
        step(3);
        check_dispatch("after rst", 4'b0001, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
